// File: rtl/tiny45_prefetch_if.sv
// Prefetch buffer bus: fetcher handshake, decoder instruction port and status.
// slave = prefetch buffer side, master = fetcher/decoder side.
interface tiny45_prefetch_if #(
  parameter int ADDR_W     = 23,
  parameter int DEPTH_LOG2 = 2
);
  logic [ADDR_W:1]     fetch_addr;
  logic                fetch_restart;
  logic                fetch_stall;
  logic                fetch_started;
  logic                fetch_stopped;
  logic [15:0]         fetch_data;
  logic                fetch_ready;
  logic                branch;
  logic [ADDR_W:1]     branch_addr;
  logic [31:0]         instr;
  logic [2:1]          instr_len;
  logic                instr_valid;
  logic                instr_consume;
  logic [ADDR_W:1]     pc;
  logic [DEPTH_LOG2:0] level;

  modport slave (
    input  fetch_started, fetch_stopped, fetch_data, fetch_ready,
           branch, branch_addr, instr_consume,
    output fetch_addr, fetch_restart, fetch_stall,
           instr, instr_len, instr_valid, pc, level
  );

  modport master (
    output fetch_started, fetch_stopped, fetch_data, fetch_ready,
           branch, branch_addr, instr_consume,
    input  fetch_addr, fetch_restart, fetch_stall,
           instr, instr_len, instr_valid, pc, level
  );
endinterface

// File: rtl/tiny45_prefetch.sv
// tiny45 instruction prefetch ring buffer of 2^DEPTH_LOG2 halfwords.
// TINY45_PREFETCH_COMPRESSED_EN enables 16-bit instruction length decode.
//
// state   | meaning
// ST_IDLE | no fetch stream active; fetcher told to restart at fetch_addr
// ST_RUN  | fetch stream active; fetched halfwords are accepted
module tiny45_prefetch #(
  parameter int DEPTH_LOG2 = 2,
  parameter int ADDR_W     = 23
) (
  input logic              clk,
  input logic              rst,
  tiny45_prefetch_if.slave pf_io
);
  localparam logic [DEPTH_LOG2:0] LVL_FULL = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [DEPTH_LOG2:0] LVL_ONE  = (DEPTH_LOG2+1)'(1);
  localparam logic [DEPTH_LOG2:0] LVL_TWO  = (DEPTH_LOG2+1)'(2);

  typedef enum logic {ST_IDLE, ST_RUN} state_e;

  state_e                state_q, state_d;
  logic [DEPTH_LOG2:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:1]       pc_q, pc_d, faddr_q, faddr_d;
  logic [15:0]           mem_q [1 << DEPTH_LOG2];

  logic [DEPTH_LOG2-1:0] rd_idx, rd_idx_nxt, wr_idx;
  logic [15:0]           hw_lo, hw_hi;
  logic [DEPTH_LOG2:0]   level, len_hw, level_after_rd, level_next;
  logic [ADDR_W:1]       br_target;
  logic                  is_wide, valid, consume_take, write_take, running;

  assign level      = wr_ptr_q - rd_ptr_q;
  assign rd_idx     = rd_ptr_q[DEPTH_LOG2-1:0];
  assign rd_idx_nxt = rd_idx + DEPTH_LOG2'(1);
  assign wr_idx     = wr_ptr_q[DEPTH_LOG2-1:0];
  assign hw_lo      = mem_q[rd_idx];
  assign hw_hi      = mem_q[rd_idx_nxt];
  assign running    = (state_q == ST_RUN);

`ifdef TINY45_PREFETCH_COMPRESSED_EN
  // An empty buffer reports a 16-bit length rather than decoding stale RAM.
  assign is_wide   = (level != '0) && (hw_lo[1:0] == 2'b11);
  assign br_target = pf_io.branch_addr;
`else
  assign is_wide   = 1'b1;
  assign br_target = pf_io.branch_addr & ~ADDR_W'(1);
`endif

  assign len_hw       = is_wide ? LVL_TWO : LVL_ONE;
  assign valid        = (level >= len_hw);
  assign consume_take = pf_io.instr_consume && valid && !pf_io.branch;
  assign level_after_rd = consume_take ? (level - len_hw) : level;
  assign write_take   = pf_io.fetch_ready && running && !pf_io.branch &&
                        (level_after_rd < LVL_FULL);
  assign level_next   = pf_io.branch ? '0 :
                        (write_take ? level_after_rd + LVL_ONE : level_after_rd);

  assign pf_io.instr_valid   = valid;
  assign pf_io.instr_len     = is_wide ? 2'b10 : 2'b01;
  assign pf_io.instr         = (level == '0) ? 32'h0000_0000 :
                               (is_wide ? {hw_hi, hw_lo} : {16'h0000, hw_lo});
  assign pf_io.level         = level;
  assign pf_io.pc            = pc_q;
  assign pf_io.fetch_addr    = faddr_q;
  assign pf_io.fetch_stall   = (level_next == LVL_FULL);
  assign pf_io.fetch_restart = pf_io.branch || !running;

  always_comb begin
    state_d  = state_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    pc_d     = pc_q;
    faddr_d  = faddr_q;
    if (pf_io.branch) begin
      state_d  = ST_IDLE;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      pc_d     = br_target;
      faddr_d  = br_target;
    end else begin
      if (pf_io.fetch_started) begin
        state_d = ST_RUN;
      end else if (pf_io.fetch_stopped) begin
        state_d = ST_IDLE;
      end
      if (consume_take) begin
        rd_ptr_d = rd_ptr_q + len_hw;
        pc_d     = pc_q + ADDR_W'(len_hw);
      end
      if (write_take) begin
        wr_ptr_d = wr_ptr_q + LVL_ONE;
        faddr_d  = faddr_q + ADDR_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      pc_q     <= '0;
      faddr_q  <= '0;
    end else begin
      state_q  <= state_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      pc_q     <= pc_d;
      faddr_q  <= faddr_d;
    end
  end

  // RAM contents survive reset; level = 0 makes them unreachable.
  always_ff @(posedge clk) begin
    if (write_take) begin
      mem_q[wr_idx] <= pf_io.fetch_data;
    end
  end
endmodule

// File: tb/tb_tiny45_prefetch.sv
// Randomized bench for tiny45_prefetch against a queue-based reference model.
module tb_tiny45_prefetch;
  localparam int DL    = 2;
  localparam int AW    = 23;
  localparam int DEPTH = 1 << DL;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  tiny45_prefetch_if #(.ADDR_W(AW), .DEPTH_LOG2(DL)) pf();
  tiny45_prefetch #(.DEPTH_LOG2(DL), .ADDR_W(AW)) dut (.clk(clk), .rst(rst), .pf_io(pf));

  int n_vec = 0;
  int n_err = 0;

  logic [15:0]   hq[$];
  logic [AW-1:0] m_pc = '0;
  bit            m_run = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int mlen();
`ifdef TINY45_PREFETCH_COMPRESSED_EN
    if (hq.size() == 0) return 1;
    return (hq[0][1:0] == 2'b11) ? 2 : 1;
`else
    return 2;
`endif
  endfunction

  task automatic idle();
    pf.fetch_ready   = 1'b0;
    pf.fetch_data    = 16'h0000;
    pf.fetch_started = 1'b0;
    pf.fetch_stopped = 1'b0;
    pf.branch        = 1'b0;
    pf.branch_addr   = '0;
    pf.instr_consume = 1'b0;
  endtask

  task automatic model_reset();
    hq.delete();
    m_pc  = '0;
    m_run = 1'b0;
  endtask

  // Drive one cycle of inputs, check pre-edge outputs, advance model, clock.
  task automatic step(input bit fr, input logic [15:0] fd, input bit fs, input bit fp,
                      input bit br, input logic [AW-1:0] ba, input bit cons);
    int n;
    bit v;
    logic [AW-1:0] fa;
    pf.fetch_ready   = fr;
    pf.fetch_data    = fd;
    pf.fetch_started = fs;
    pf.fetch_stopped = fp;
    pf.branch        = br;
    pf.branch_addr   = ba;
    pf.instr_consume = cons;
    #1;
    n  = mlen();
    v  = (hq.size() >= n);
    fa = m_pc + AW'(hq.size());
    chk("level", 32'(pf.level), 32'(hq.size()));
    chk("instr_valid", 32'(pf.instr_valid), 32'(v));
    chk("instr_len", 32'(pf.instr_len), (n == 2) ? 32'd2 : 32'd1);
    if (hq.size() == 0)
      chk("instr_empty", pf.instr, 32'h0);
    else if (v)
      chk("instr", pf.instr, (n == 2) ? {hq[1], hq[0]} : {16'h0000, hq[0]});
    chk("pc", 32'(pf.pc), 32'(m_pc));
    chk("fetch_addr", 32'(pf.fetch_addr), 32'(fa));
    chk("fetch_restart", 32'(pf.fetch_restart), 32'(br || !m_run));
    if (br) begin
      hq.delete();
`ifdef TINY45_PREFETCH_COMPRESSED_EN
      m_pc = ba;
`else
      m_pc = {ba[AW-1:1], 1'b0};
`endif
      m_run = 1'b0;
    end else begin
      if (cons && v) begin
        for (int i = 0; i < n; i++) void'(hq.pop_front());
        m_pc = m_pc + AW'(n);
      end
      if (fr && m_run && hq.size() < DEPTH) hq.push_back(fd);
      if (fs) m_run = 1'b1;
      else if (fp) m_run = 1'b0;
    end
    chk("fetch_stall", 32'(pf.fetch_stall), 32'(hq.size() == DEPTH));
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wr(input logic [15:0] d);
    step(1'b1, d, 1'b0, 1'b0, 1'b0, '0, 1'b0);
  endtask

  initial begin
    logic [AW-1:0] ba;
    idle();
    repeat (3) @(negedge clk);
    #1;
    chk("rst_level", 32'(pf.level), 32'd0);
    chk("rst_pc", 32'(pf.pc), 32'd0);
    chk("rst_instr", pf.instr, 32'h0);
    chk("rst_restart", 32'(pf.fetch_restart), 32'd1);
`ifdef TINY45_PREFETCH_COMPRESSED_EN
    chk("rst_len", 32'(pf.instr_len), 32'd1);
`else
    chk("rst_len", 32'(pf.instr_len), 32'd2);
`endif
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Fill and first instruction
    step(1'b0, '0, 1'b1, 1'b0, 1'b0, '0, 1'b0);
    wr(16'h0093);
    wr(16'h0010);
    idle(); #1;
    chk("seq_instr", pf.instr, 32'h0010_0093);
    chk("seq_len", 32'(pf.instr_len), 32'd2);
    chk("seq_valid", 32'(pf.instr_valid), 32'd1);
    wr(16'h4501);
    wr(16'h8082);
    wr(16'hDEAD);
    idle(); #1;
    chk("full_level", 32'(pf.level), 32'd4);
    chk("full_faddr", 32'(pf.fetch_addr), 32'd4);
    chk("full_stall", 32'(pf.fetch_stall), 32'd1);
    step(1'b0, '0, 1'b0, 1'b0, 1'b0, '0, 1'b1);
    idle(); #1;
    chk("cons_pc", 32'(pf.pc), 32'd2);
`ifdef TINY45_PREFETCH_COMPRESSED_EN
    chk("cons_instr", pf.instr, 32'h0000_4501);
    chk("cons_len", 32'(pf.instr_len), 32'd1);
`else
    chk("cons_instr", pf.instr, 32'h8082_4501);
    chk("cons_len", 32'(pf.instr_len), 32'd2);
`endif

    // Full buffer with simultaneous consume and write
    wr(16'h1111);
    wr(16'h2222);
    step(1'b1, 16'h3333, 1'b0, 1'b0, 1'b0, '0, 1'b1);
    idle(); #1;
`ifdef TINY45_PREFETCH_COMPRESSED_EN
    chk("fullrw_level", 32'(pf.level), 32'd4);
    chk("fullrw_stall", 32'(pf.fetch_stall), 32'd1);
    step(1'b0, '0, 1'b0, 1'b0, 1'b0, '0, 1'b1);
`else
    chk("fullrw_level", 32'(pf.level), 32'd3);
`endif

    // Branch with level 3, concurrent write and consume discarded
    step(1'b1, 16'hBEEF, 1'b0, 1'b0, 1'b1, AW'(23'h123456), 1'b1);
    idle(); #1;
    chk("br_level", 32'(pf.level), 32'd0);
    chk("br_pc", 32'(pf.pc), 32'h123456);
    chk("br_faddr", 32'(pf.fetch_addr), 32'h123456);
    chk("br_valid", 32'(pf.instr_valid), 32'd0);
    chk("br_restart", 32'(pf.fetch_restart), 32'd1);
    step(1'b0, '0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    step(1'b1, 16'h7777, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0, 1'b0, '0, 1'b0);
    idle(); #1;
    chk("started_restart", 32'(pf.fetch_restart), 32'd0);

`ifdef TINY45_PREFETCH_COMPRESSED_EN
    // 32-bit instruction straddling the ring end
    for (int i = 0; i < 3; i++) wr(16'h4501);
    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b0, 1'b0, 1'b0, '0, 1'b1);
    wr(16'h0513);
    idle(); #1;
    chk("wrap_valid_lo", 32'(pf.instr_valid), 32'd0);
    wr(16'h0000);
    idle(); #1;
    chk("wrap_instr", pf.instr, 32'h0000_0513);
    chk("wrap_valid", 32'(pf.instr_valid), 32'd1);
`endif

    // Randomized traffic
    for (int k = 0; k < 3000; k++) begin
      ba = ($urandom_range(0, 3) == 0) ? ({AW{1'b1}} - AW'($urandom_range(0, 3)))
                                       : AW'($urandom);
      step($urandom_range(0, 9) < 7, 16'($urandom), $urandom_range(0, 9) == 0,
           $urandom_range(0, 19) == 0, $urandom_range(0, 29) == 0, ba,
           $urandom_range(0, 1) == 1);
    end

    // Asynchronous reset between edges
    step(1'b0, '0, 1'b1, 1'b0, 1'b0, '0, 1'b0);
    wr(16'h0093);
    wr(16'h0010);
    idle();
    rst = 1'b1;
    #1;
    model_reset();
    chk("arst_level", 32'(pf.level), 32'd0);
    chk("arst_pc", 32'(pf.pc), 32'd0);
    chk("arst_faddr", 32'(pf.fetch_addr), 32'd0);
    chk("arst_valid", 32'(pf.instr_valid), 32'd0);
    chk("arst_instr", pf.instr, 32'h0);
    chk("arst_restart", 32'(pf.fetch_restart), 32'd1);
    chk("arst_stall", 32'(pf.fetch_stall), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    step(1'b0, '0, 1'b1, 1'b0, 1'b0, '0, 1'b0);
    wr(16'h4501);
    wr(16'h0000);
    idle(); #1;
`ifdef TINY45_PREFETCH_COMPRESSED_EN
    chk("c_len", 32'(pf.instr_len), 32'd1);
`else
    chk("c_len", 32'(pf.instr_len), 32'd2);
`endif
    chk("c_instr", pf.instr, 32'h0000_4501);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
